// File: rtl/node_sched_pkg.sv
// Shared types and defaults for the compute-node scheduler.
// Imported by node_sched and its round-robin picker.
package node_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_LATENCY = 2;

    // Index width: at least one bit even for tiny ranges.
    function automatic int idw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/node_sched_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping modulo N.
module rr_pick
    import node_sched_pkg::*;
#(
    parameter int N   = DEF_NUM_REQ,
    parameter int IDW = idw_f(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [N-1:0]   gnt_onehot,
    output logic [IDW-1:0] gnt_id
);

    localparam logic [IDW:0] NN = (IDW+1)'(N);

    logic           found;
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    always_comb begin
        any        = |req;
        gnt_onehot = '0;
        gnt_id     = '0;
        found      = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= NN) begin
                sum = sum - NN;
            end
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_id          = idx;
            end
        end
    end

endmodule

// File: rtl/node_sched.sv
// Shares one fixed-latency compute node among NUM_REQ requesters,
// one transaction at a time, with round-robin fairness.
module node_sched
    import node_sched_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    parameter int  WIDTH   = DEF_WIDTH,
    parameter int  LATENCY = DEF_LATENCY,
    localparam int IDW     = idw_f(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         dp_a,
    output logic [WIDTH-1:0]         dp_b,
    output logic                     dp_issue,
    input  logic [WIDTH-1:0]         dp_result,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_data,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic                     busy,
    output logic [IDW-1:0]           grant_id
);

    localparam int             CW       = idw_f(LATENCY);
    localparam logic [CW-1:0]  CNT_LAST = CW'(LATENCY - 1);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NUM_REQ - 1);

    state_t               state;
    state_t               state_next;
    logic [IDW-1:0]       ptr;
    logic [CW-1:0]        cnt;
    logic                 pick_any;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDW-1:0]       pick_id;
    logic                 accept;
    logic                 sample;
    logic                 done;

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_pick (
        .req        (req_valid),
        .ptr        (ptr),
        .any        (pick_any),
        .gnt_onehot (pick_onehot),
        .gnt_id     (pick_id)
    );

    always_comb begin
        state_next = state;
        req_ready  = '0;
        resp_valid = '0;
        dp_issue   = 1'b0;
        accept     = 1'b0;
        sample     = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    req_ready  = pick_onehot;
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                dp_issue   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    sample     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid[grant_id] = 1'b1;
                if (resp_ready[grant_id]) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            cnt       <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            resp_data <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                dp_a     <= req_a[int'(pick_id)*WIDTH +: WIDTH];
                dp_b     <= req_b[int'(pick_id)*WIDTH +: WIDTH];
                grant_id <= pick_id;
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + CW'(1);
            end
            if (sample) begin
                resp_data <= dp_result;
            end
            // Explicit wrap keeps ptr legal for non-power-of-two counts.
            if (done) begin
                ptr <= (grant_id == ID_LAST) ? '0 : grant_id + IDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_node_sched.sv
// Self-checking bench for node_sched: vector table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_node_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int L  = 2;
    localparam int N3 = 3;
    localparam int L3 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   dp_a, dp_b, dp_result, resp_data;
    logic           dp_issue, busy;
    logic [1:0]     grant_id;

    logic [N3-1:0]   req_valid3, req_ready3, resp_valid3, resp_ready3;
    logic [N3*W-1:0] req_a3, req_b3;
    logic [W-1:0]    dp_a3, dp_b3, dp_result3, resp_data3;
    logic            dp_issue3, busy3;
    logic [1:0]      grant_id3;

    node_sched #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .dp_a(dp_a), .dp_b(dp_b), .dp_issue(dp_issue),
        .dp_result(dp_result),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_ready(resp_ready),
        .busy(busy), .grant_id(grant_id)
    );

    node_sched #(.NUM_REQ(N3), .WIDTH(W), .LATENCY(L3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3),
        .dp_a(dp_a3), .dp_b(dp_b3), .dp_issue(dp_issue3),
        .dp_result(dp_result3),
        .resp_valid(resp_valid3), .resp_data(resp_data3),
        .resp_ready(resp_ready3),
        .busy(busy3), .grant_id(grant_id3)
    );

    function automatic logic [7:0] node_f(input logic [7:0] a, input logic [7:0] b);
        return a ^ b ^ 8'hC3;
    endfunction

    // Node models: correct result only in the issue+LATENCY cycle.
    logic [1:0] n_v  = '0;
    logic [7:0] n_d [2];
    logic       n3_v = 1'b0;
    logic [7:0] n3_d;
    logic [7:0] junk = 8'h5A;

    always @(posedge clk) begin
        n_v[0] <= dp_issue;
        n_d[0] <= node_f(dp_a, dp_b);
        n_v[1] <= n_v[0];
        n_d[1] <= n_d[0];
        n3_v   <= dp_issue3;
        n3_d   <= node_f(dp_a3, dp_b3);
        junk   <= 8'($urandom_range(1, 255));
    end

    assign dp_result  = n_v[1] ? n_d[1] : (n_d[1] ^ junk);
    assign dp_result3 = n3_v ? n3_d : (n3_d ^ junk);

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference model of u_dut.
    int         cyc    = 0;
    bit         m_idle = 1'b1;
    int         m_ptr  = 0;
    int         m_g    = 0;
    int         m_t0   = 0;
    logic [7:0] m_a    = '0;
    logic [7:0] m_b    = '0;
    logic [7:0] m_res  = '0;
    logic [N-1:0] last_ready = '0;
    int acc_id [$];
    int acc_t  [$];

    task automatic model_check();
        logic [N-1:0] e_ready;
        logic [N-1:0] e_resp;
        logic         e_issue;
        logic         e_busy;
        int           g;
        int           d;
        int           p;
        e_ready = '0;
        e_resp  = '0;
        e_issue = 1'b0;
        e_busy  = 1'b0;
        g       = -1;
        d       = 0;
        last_ready = req_ready;
        if (rst) begin
            m_idle = 1'b1;
            m_ptr  = 0;
            m_g    = 0;
            m_a    = '0;
            m_b    = '0;
            m_res  = '0;
            return;
        end
        if (m_idle) begin
            for (int k = 0; k < N; k++) begin
                p = (m_ptr + k) % N;
                if (g < 0 && req_valid[p]) g = p;
            end
            if (g >= 0) e_ready[g] = 1'b1;
        end else begin
            d       = cyc - m_t0;
            e_busy  = 1'b1;
            e_issue = (d == 1);
            if (d >= L + 2) e_resp[m_g] = 1'b1;
        end
        check("cycle", {req_ready, dp_issue, resp_valid, busy, grant_id, dp_a, dp_b},
              {e_ready, e_issue, e_resp, e_busy, 2'(m_g), m_a, m_b});
        if (e_resp != '0) check("resp_data", resp_data, m_res);
        if (g >= 0) begin
            m_idle = 1'b0;
            m_t0   = cyc;
            m_g    = g;
            m_a    = req_a[g*W +: W];
            m_b    = req_b[g*W +: W];
            m_res  = node_f(m_a, m_b);
            acc_id.push_back(g);
            acc_t.push_back(cyc);
        end else if (!m_idle && e_resp[m_g] && resp_ready[m_g]) begin
            m_idle = 1'b1;
            m_ptr  = (m_g + 1) % N;
        end
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        model_check();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            half();
            fin();
        end
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] exp_ready;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [8];
    int   exp_fair [6];

    initial begin
        vecs[0] = '{4'b1010, 8'h11, 8'h22, 4'b0010, 8'hF0};
        vecs[1] = '{4'b1011, 8'hFF, 8'h00, 4'b1000, 8'h3C};
        vecs[2] = '{4'b0110, 8'h80, 8'h01, 4'b0010, 8'h42};
        vecs[3] = '{4'b0011, 8'hC3, 8'hC3, 4'b0001, 8'hC3};
        vecs[4] = '{4'b1000, 8'h12, 8'h34, 4'b1000, 8'hE5};
        vecs[5] = '{4'b1111, 8'h00, 8'h00, 4'b0001, 8'hC3};
        vecs[6] = '{4'b0001, 8'h01, 8'h02, 4'b0001, 8'hC0};
        vecs[7] = '{4'b0100, 8'hAA, 8'h55, 4'b0100, 8'h3C};
        exp_fair = '{0, 1, 2, 3, 0, 1};

        rst         = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        resp_ready  = '0;
        req_valid3  = '0;
        req_a3      = '0;
        req_b3      = '0;
        resp_ready3 = '0;
        @(posedge clk);
        #1;

        // Reset values
        ticks(3);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            half();
            check("reset_outs", {req_ready, dp_a, dp_b, dp_issue, resp_valid,
                                 resp_data, busy, grant_id}, '0);
            fin();
        end

        // Arbitration vector table, one full transaction per record
        for (int i = 0; i < 8; i++) begin
            req_valid  = vecs[i].valid;
            req_a      = {N{vecs[i].a}};
            req_b      = {N{vecs[i].b}};
            resp_ready = '0;
            half();
            check("vec_ready", req_ready, vecs[i].exp_ready);
            fin();
            req_valid = '0;
            ticks(L + 1);
            half();
            check("vec_resp_valid", resp_valid, vecs[i].exp_ready);
            check("vec_resp_data", resp_data, vecs[i].exp_data);
            resp_ready = '1;
            fin();
        end

        // Single request from requester 2
        req_valid  = 4'b0100;
        req_a      = '0;
        req_b      = '0;
        req_a[2*W +: W] = 8'h3C;
        req_b[2*W +: W] = 8'hA5;
        resp_ready = 4'b0100;
        half();
        check("single_ready", req_ready, 4'b0100);
        fin();
        req_valid = '0;
        half();
        check("single_issue", {dp_issue, dp_a, dp_b}, {1'b1, 8'h3C, 8'hA5});
        fin();
        ticks(2);
        half();
        check("single_resp", {resp_valid, resp_data}, {4'b0100, 8'h5A});
        fin();

        // Fairness with all requesters valid
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        acc_id.delete();
        acc_t.delete();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 8'($urandom);
            req_b[i*W +: W] = 8'($urandom);
        end
        req_valid  = '1;
        resp_ready = '1;
        for (int c = 0; c < 60 && acc_id.size() < 6; c++) ticks(1);
        req_valid = '0;
        check("fair_count", acc_id.size(), 6);
        for (int i = 0; i < acc_id.size() && i < 6; i++) begin
            check("fair_id", acc_id[i], exp_fair[i]);
            if (i > 0) check("fair_gap", acc_t[i] - acc_t[i-1], L + 3);
        end
        ticks(L + 4);

        // Backpressure on requester 1
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        req_valid  = 4'b0010;
        req_a[1*W +: W] = 8'h66;
        req_b[1*W +: W] = 8'h0F;
        resp_ready = '0;
        half();
        check("bp_grant", req_ready, 4'b0010);
        fin();
        req_valid = '1;
        ticks(L + 1);
        resp_ready = 4'b1101;
        for (int i = 0; i < 7; i++) begin
            half();
            check("bp_hold", {resp_valid, resp_data, req_ready},
                  {4'b0010, node_f(8'h66, 8'h0F), 4'b0000});
            fin();
        end
        resp_ready = 4'b0010;
        half();
        check("bp_release", resp_valid, 4'b0010);
        fin();
        half();
        check("bp_next", req_ready, 4'b0100);
        fin();
        req_valid  = '0;
        resp_ready = '1;
        ticks(L + 4);

        // Reset during WAIT
        req_valid  = 4'b0100;
        resp_ready = '1;
        half();
        check("mid_grant", req_ready, 4'b0100);
        fin();
        req_valid = '0;
        ticks(1);
        rst = 1'b1;
        half();
        check("mid_busy", busy, 1'b1);
        fin();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            half();
            check("mid_no_resp", {resp_valid, busy}, '0);
            fin();
        end
        req_valid = '1;
        half();
        check("mid_regrant", req_ready, 4'b0001);
        fin();
        req_valid = '0;
        ticks(L + 4);

        // Three requesters, latency one
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        resp_ready3 = '1;
        req_valid3  = 3'b010;
        half();
        check("l1_first", req_ready3, 3'b010);
        fin();
        req_valid3 = '0;
        ticks(L3 + 1);
        half();
        check("l1_first_resp", resp_valid3, 3'b010);
        fin();
        req_valid3 = 3'b101;
        req_a3     = {8'h21, 8'h00, 8'h10};
        req_b3     = {8'h43, 8'h00, 8'h01};
        half();
        check("l1_grant2", req_ready3, 3'b100);
        fin();
        req_valid3 = 3'b001;
        half();
        check("l1_issue", {dp_issue3, dp_a3, dp_b3}, {1'b1, 8'h21, 8'h43});
        fin();
        half();
        check("l1_sample_cycle", resp_valid3, 3'b000);
        fin();
        half();
        check("l1_resp", {resp_valid3, resp_data3}, {3'b100, 8'hA1});
        fin();
        half();
        check("l1_grant0", {req_ready3, grant_id3}, {3'b001, 2'd2});
        fin();
        req_valid3 = '0;
        half();
        check("l1_issue0", {dp_issue3, dp_a3, dp_b3}, {1'b1, 8'h10, 8'h01});
        fin();
        ticks(L3 + 3);

        // Randomized traffic against the model
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && last_ready[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    req_valid[i]    = ($urandom_range(0, 2) == 0);
                    req_a[i*W +: W] = 8'($urandom);
                    req_b[i*W +: W] = 8'($urandom);
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = 4'($urandom);
            rst        = ($urandom_range(0, 149) == 0);
            ticks(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/node_sched.md
# node_sched

Round-robin scheduler that shares one registered compute node among `NUM_REQ` requesters. It accepts an operand pair from one requester at a time, drives the node's operand inputs with a one-cycle issue strobe, and samples the node result after a fixed `LATENCY`. It returns the result to the granted requester with a valid/ready handshake. It sits between the requester ports and the single node instance in the datapath.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `WIDTH`, default 8: operand and result width.
- `LATENCY`, default 2: cycles from the issue cycle to the cycle in which `dp_result` is valid; must be ≥1.
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, `NUM_REQ`: per-requester request valid.
- `req_ready`, out, `NUM_REQ`: per-requester accept; at most one bit is high.
- `req_a`, in, `NUM_REQ*WIDTH`: packed operand A; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_b`, in, `NUM_REQ*WIDTH`: packed operand B, same packing as `req_a`.
- `dp_a`, out, `WIDTH`: operand A to the node.
- `dp_b`, out, `WIDTH`: operand B to the node.
- `dp_issue`, out, 1: one-cycle strobe marking the issue cycle.
- `dp_result`, in, `WIDTH`: node result.
- `resp_valid`, out, `NUM_REQ`: one-hot response valid.
- `resp_data`, out, `WIDTH`: response data, shared by all requesters.
- `resp_ready`, in, `NUM_REQ`: per-requester response accept.
- `busy`, out, 1: high whenever the state is not IDLE.
- `grant_id`, out, `IDW = max(1, $clog2(NUM_REQ))`: index of the current or last grant.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - A combinational round-robin pick searches `req_valid` starting at pointer `ptr` and upward, modulo `NUM_REQ`.
  - If any request is valid, `req_ready[g]` is asserted for the winner g in the same cycle. The handshake completes in that cycle.
  - On the handshake: `req_a` and `req_b` of slot g are latched into `dp_a`/`dp_b`, g is latched into `grant_id`, and the FSM moves to ISSUE.
  - If no request is valid, the FSM stays in IDLE.
- **ISSUE**
  - `dp_issue` = 1 for exactly one cycle.
  - The wait counter is cleared and the FSM moves to WAIT.
- **WAIT**
  - The counter increments each cycle.
  - In the cycle where the count equals `LATENCY-1` (the issue cycle plus `LATENCY`), `dp_result` is registered into `resp_data` and the FSM moves to RESP.
  - `dp_result` is ignored in every other cycle.
- **RESP**
  - `resp_valid[grant_id]` = 1; `resp_data` is held.
  - When `resp_ready[grant_id]` is high, the handshake completes: `ptr` ← (`grant_id` + 1) mod `NUM_REQ`, and the FSM moves to IDLE.
  - `resp_ready` bits of other requesters are ignored.
- `dp_a` and `dp_b` hold their latched values in every state until the next accept.
- `req_ready` is 0 in every state other than IDLE.
- The wrap-around index arithmetic uses `IDW` bits. For a non-power-of-two `NUM_REQ`, `ptr` wraps explicitly from `NUM_REQ-1` to 0.
- Requesters must hold `req_valid` and their operands stable until `req_ready`. Dropping `req_valid` before grant is legal and leaves no state behind.

## Timing
- **Reset:** state = IDLE, `ptr` = 0, `grant_id` = 0, `dp_a` = `dp_b` = 0, `resp_data` = 0. All of `dp_issue`, `req_ready`, `resp_valid` and `busy` are 0.
- **Transaction timeline,** with accept in cycle T:
  - T+1: `dp_issue` high.
  - T+1+`LATENCY`: sample cycle.
  - T+2+`LATENCY`: first cycle of `resp_valid`.
- **Minimum spacing:** back-to-back accepts are `LATENCY+3` cycles apart when `resp_ready` is always high.
- **Reset mid-operation:**
  - Any in-flight transaction is discarded. No `resp_valid` is produced for it.
  - `ptr` returns to 0.
  - Reset takes priority over every other transition in the same cycle.
- **All requesters valid:** grants rotate strictly in the order `ptr`, `ptr+1`, and so on, so no requester waits more than `NUM_REQ-1` transactions.
- **`resp_ready` held low:** the FSM stays in RESP indefinitely, with `resp_valid` and `resp_data` stable.

## Structure
- Package `node_sched_pkg` contains:
  - the `state_t` enum (IDLE, ISSUE, WAIT, RESP);
  - the `IDW` computation function;
  - the default-parameter localparams.
- Sub-module `rr_pick`: a purely combinational round-robin priority selector.
  - Inputs: `req` [N], `ptr` [IDW].
  - Outputs: `any`, `gnt_onehot` [N], `gnt_id` [IDW].
  - It is reused by other arbiters in the design.
- The top level holds the FSM, the wait counter, the operand and result registers, and `ptr`.

## Test plan
- **Reset values:** hold `rst` for 3 cycles, then release with all inputs at 0 → every output is 0 and `busy` = 0 for 10 cycles.
- **Single request:** with `LATENCY` = 2, requester 2 drives a = 0x3C, b = 0xA5, and the bench model returns 0x5A two cycles after `dp_issue`.
  - `req_ready[2]` is high in cycle T.
  - `dp_issue` is high at T+1 with `dp_a` = 0x3C and `dp_b` = 0xA5.
  - `resp_valid` = 0b0100 and `resp_data` = 0x5A from T+4.
- **Fairness:** all 4 requesters are continuously valid and `resp_ready` is tied high → grant order is 0, 1, 2, 3, 0, 1, and accepts are exactly 5 cycles apart.
- **Backpressure:** `resp_ready[1]` is held low for 7 cycles → `resp_valid[1]` and `resp_data` stay stable, `req_ready` stays 0, and the next accept happens 1 cycle after `resp_ready[1]` rises.
- **Reset mid-operation:** assert `rst` in the WAIT cycle → no `resp_valid` follows, and the next grant with all requesters valid goes to requester 0.
- **`LATENCY` = 1 with `NUM_REQ` = 3:** requesters 2 and 0 are valid with `ptr` = 2 → the grant goes to 2, then to 0. Sampling occurs exactly 1 cycle after `dp_issue`.
